// File: rtl/noc_arb_mux_5to1_if.sv
// -----------------------------------------------------------------------------
// noc_arb_mux_5to1_if
// Handshake and data bundle for the 5-to-1 NoC output-port merger.
//
// Signals:
//   in_valid  [PORTS]            per-port flit valid, bit i = port i
//   in_data   [PORTS*DATA_WIDTH] per-port flit, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_tail   [PORTS]            per-port last-flit-of-packet flag
//   in_ready  [PORTS]            per-port accept (combinational in the merger)
//   out_valid                    registered output flit valid
//   out_data  [DATA_WIDTH]       registered output flit
//   out_tail                     registered tail flag of out_data
//   out_ready                    downstream accept
//   grant_sel [3]                locked port index, 3'b111 when no lock
//
// Modports:
//   master - environment side (sources drive flits, sink drives out_ready)
//   slave  - merger side
// -----------------------------------------------------------------------------
interface noc_arb_mux_5to1_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PORTS      = 5
);
    logic [PORTS-1:0]            in_valid;
    logic [PORTS*DATA_WIDTH-1:0] in_data;
    logic [PORTS-1:0]            in_tail;
    logic [PORTS-1:0]            in_ready;
    logic                        out_valid;
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        out_tail;
    logic                        out_ready;
    logic [2:0]                  grant_sel;

    modport master (
        output in_valid, in_data, in_tail, out_ready,
        input  in_ready, out_valid, out_data, out_tail, grant_sel
    );

    modport slave (
        input  in_valid, in_data, in_tail, out_ready,
        output in_ready, out_valid, out_data, out_tail, grant_sel
    );
endinterface

// File: rtl/noc_arb_mux_5to1.sv
// -----------------------------------------------------------------------------
// noc_arb_mux_5to1
// Output-port merger for the minimal NoC router. Five input channels
// (0=N, 1=E, 2=S, 3=W, 4=Local) are merged onto one registered output link.
// Packets are arbitrated round-robin; once a head flit is accepted the port
// keeps the link (wormhole lock) until its tail flit is accepted.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          noc_arb_mux_5to1_if.slave (flit inputs, registered output,
//                in_ready, grant_sel)
//   pkt_count    (NOC_ARB_PKT_CNT_EN only) 16-bit count of accepted tails
//   pkt_dbg_port (NOC_ARB_PKT_CNT_EN only) port of the last accepted tail
//
// Optional feature macro: NOC_ARB_PKT_CNT_EN (undefined by default).
// -----------------------------------------------------------------------------
module noc_arb_mux_5to1 #(
    parameter int DATA_WIDTH = 32,
    parameter int PORTS      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    noc_arb_mux_5to1_if.slave    bus
`ifdef NOC_ARB_PKT_CNT_EN
    ,
    output logic [15:0]          pkt_count,
    output logic [2:0]           pkt_dbg_port
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] NO_GRANT = 3'b111;

    state_t                state_q;
    logic [2:0]            grant_q;
    logic [2:0]            rr_ptr_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_tail_q;

    logic [DATA_WIDTH-1:0] slice_w [PORTS];
    logic                  load;
    logic                  win_found;
    logic [2:0]            win_idx;
    logic [3:0]            cand;
    logic [2:0]            sel_idx;
    logic                  sel_req;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_tail;
    logic                  xfer;
    logic [2:0]            rr_ptr_d;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_slice
            assign slice_w[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Output register can take a new flit when empty or being drained.
    assign load = !out_valid_q || bus.out_ready;

    // Round-robin search starting at rr_ptr; the first requesting port wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < PORTS; k++) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= 4'(PORTS)) begin
                cand = cand - 4'(PORTS);
            end
            if (!win_found && bus.in_valid[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    // While locked, only the granted port is eligible, valid or not.
    assign sel_idx = (state_q == LOCKED) ? grant_q : win_idx;
    assign sel_req = (state_q == LOCKED) ? 1'b1 : win_found;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_ready
            assign bus.in_ready[gi] = rst_n && sel_req && load && (sel_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        sel_tail = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (sel_idx == 3'(i)) begin
                sel_data = slice_w[i];
                sel_tail = bus.in_tail[i];
            end
        end
    end

    assign xfer     = |(bus.in_valid & bus.in_ready);
    assign rr_ptr_d = (sel_idx == 3'(PORTS-1)) ? 3'd0 : sel_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= NO_GRANT;
            rr_ptr_q    <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tail_q  <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_tail_q  <= sel_tail;
            if (sel_tail) begin
                state_q  <= IDLE;
                grant_q  <= NO_GRANT;
                rr_ptr_q <= rr_ptr_d;
            end else begin
                state_q <= LOCKED;
                grant_q <= sel_idx;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tail  = out_tail_q;
    assign bus.grant_sel = grant_q;

`ifdef NOC_ARB_PKT_CNT_EN
    logic [15:0] pkt_count_q;
    logic [2:0]  pkt_dbg_port_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_count_q    <= 16'd0;
            pkt_dbg_port_q <= NO_GRANT;
        end else if (xfer && sel_tail) begin
            pkt_count_q    <= pkt_count_q + 16'd1;
            pkt_dbg_port_q <= sel_idx;
        end
    end

    assign pkt_count    = pkt_count_q;
    assign pkt_dbg_port = pkt_dbg_port_q;
`endif

endmodule

// File: tb/tb_noc_arb_mux_5to1.sv
// -----------------------------------------------------------------------------
// tb_noc_arb_mux_5to1
// Directed bench for noc_arb_mux_5to1. Expected flits are queued when the
// bench expects a port to be accepted and checked against the output link
// when the sink takes them.
// -----------------------------------------------------------------------------
module tb_noc_arb_mux_5to1;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    noc_arb_mux_5to1_if #(.DATA_WIDTH(DW), .PORTS(5)) bus ();

`ifdef NOC_ARB_PKT_CNT_EN
    logic [15:0] pkt_count;
    logic [2:0]  pkt_dbg_port;
`endif

    noc_arb_mux_5to1 #(.DATA_WIDTH(DW), .PORTS(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus)
`ifdef NOC_ARB_PKT_CNT_EN
        ,
        .pkt_count    (pkt_count),
        .pkt_dbg_port (pkt_dbg_port)
`endif
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b1;
    logic [32:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flit(input int p, input int s);
        return 32'hA000_0000 | (32'(p) << 16) | 32'(s);
    endfunction

    task automatic set_port(input int p, input logic v, input logic [31:0] d, input logic t);
        bus.in_valid[p]          = v;
        bus.in_data[p*DW +: DW]  = d;
        bus.in_tail[p]           = t;
    endtask

    // One cycle: check in_ready against the bench's expectation, queue the
    // flit the bench expects to be accepted, then advance past the edge.
    task automatic step(input string tag, input logic [4:0] exp_rdy);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'(exp_rdy));
        for (int i = 0; i < 5; i++) begin
            if (exp_rdy[i] && bus.in_valid[i]) begin
                exp_q.push_back({bus.in_tail[i], bus.in_data[i*DW +: DW]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: each flit taken by the sink must match the queue head.
    always @(negedge clk) begin
        logic [32:0] e;
        if (mon_en && rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e[31:0]);
                chk("out_tail", 32'(bus.out_tail), 32'(e[32]));
                $display("out flit %08h tail %0d", bus.out_data, bus.out_tail);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset with every port requesting ----------------
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_tail   = '0;
        for (int p = 0; p < 5; p++) set_port(p, 1'b1, flit(p, 0), 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_grant", 32'(bus.grant_sel), 32'd7);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---------------- single-flit round robin 0,1,2,3,4,0 ----------------
        for (int j = 0; j < 6; j++) begin
            int p;
            p = j % 5;
            step("rr", 5'(1 << p));
            if (j == 0) chk("ovalid_rise", 32'(bus.out_valid), 32'd1);
            set_port(p, 1'b1, flit(p, j + 1), 1'b1);
        end
        bus.in_valid = '0;
        step("idle0", 5'b00000);
        step("idle1", 5'b00000);

        // ---------------- port 2 wormhole packet while port 1 waits ----------------
        set_port(1, 1'b1, flit(1, 20), 1'b1);
        step("p1a", 5'b00010);                  // rr_ptr -> 2
        set_port(1, 1'b1, flit(1, 21), 1'b1);
        set_port(2, 1'b1, flit(2, 30), 1'b0);
        step("p2h", 5'b00100);
        chk("lock2_grant", 32'(bus.grant_sel), 32'd2);
        set_port(2, 1'b1, flit(2, 31), 1'b0);
        step("p2b", 5'b00100);
        chk("lock2_hold", 32'(bus.grant_sel), 32'd2);
        set_port(2, 1'b1, flit(2, 32), 1'b1);
        step("p2t", 5'b00100);
        chk("unlock2", 32'(bus.grant_sel), 32'd7);
        set_port(2, 1'b0, '0, 1'b0);
        set_port(4, 1'b1, flit(4, 40), 1'b1);
        step("rr3", 5'b10000);                  // rr_ptr=3 so port 4 beats port 1
        set_port(4, 1'b0, '0, 1'b0);
        step("p1b", 5'b00010);
        set_port(1, 1'b0, '0, 1'b0);
        step("idle2", 5'b00000);

        // ---------------- backpressure with DEADBEEF ----------------
        bus.out_ready = 1'b0;
        set_port(0, 1'b1, 32'hDEADBEEF, 1'b1);
        step("bp_load", 5'b00001);              // rr_ptr -> 1
        set_port(0, 1'b1, flit(0, 50), 1'b1);
        set_port(1, 1'b1, flit(1, 51), 1'b1);
        for (int c = 0; c < 4; c++) begin
            step("bp_stall", 5'b00000);
            chk("bp_data", bus.out_data, 32'hDEADBEEF);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        step("bp_p1", 5'b00010);
        set_port(1, 1'b0, '0, 1'b0);
        step("bp_p0", 5'b00001);
        set_port(0, 1'b0, '0, 1'b0);
        step("idle3", 5'b00000);
        step("idle4", 5'b00000);
        chk("sb_empty_a", 32'(exp_q.size()), 32'd0);

        // ---------------- port 3 bubble while port 4 requests ----------------
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_port(3, 1'b1, flit(3, 60), 1'b0);
        step("l3h", 5'b01000);
        set_port(3, 1'b0, flit(3, 61), 1'b1);
        set_port(4, 1'b1, flit(4, 70), 1'b1);
        step("l3bub0", 5'b01000);
        chk("l3_grant0", 32'(bus.grant_sel), 32'd3);
        step("l3bub1", 5'b01000);
        chk("l3_grant1", 32'(bus.grant_sel), 32'd3);
        set_port(3, 1'b1, flit(3, 61), 1'b1);
        step("l3t", 5'b01000);
        set_port(3, 1'b0, '0, 1'b0);
        step("p4", 5'b10000);
        set_port(4, 1'b0, '0, 1'b0);
        step("idle5", 5'b00000);
        step("idle6", 5'b00000);
        chk("sb_empty_b", 32'(exp_q.size()), 32'd0);

`ifdef NOC_ARB_PKT_CNT_EN
        // ---------------- 65537 single-flit packets wrap the counter ----------------
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b0;
        set_port(0, 1'b1, flit(0, 99), 1'b1);
        repeat (65537) @(posedge clk);
        #1;
        set_port(0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("cnt_wrap", 32'(pkt_count), 32'd1);
        chk("cnt_dbg", 32'(pkt_dbg_port), 32'd0);
`endif

        // ---------------- reset in the middle of a packet ----------------
        set_port(0, 1'b1, flit(0, 80), 1'b0);
        step("mh", 5'b00001);
        chk("mh_grant", 32'(bus.grant_sel), 32'd0);
        rst_n = 1'b0;
        exp_q.delete();                         // in-flight flit is discarded
        @(posedge clk);
        #1;
        chk("mrst_grant", 32'(bus.grant_sel), 32'd7);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_ready", 32'(bus.in_ready), 32'd0);
`ifdef NOC_ARB_PKT_CNT_EN
        chk("mrst_cnt", 32'(pkt_count), 32'd0);
`endif
        set_port(0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
        step("idle7", 5'b00000);
        chk("sb_empty_c", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
